// File: rtl/depar_pkt_arbiter_pkg.sv
// Shared constants and FSM encoding for the deparser packet arbiter.
package depar_pkt_arbiter_pkg;

    localparam int NUM_IN_MAX  = 8;
    localparam int NUM_IN_DEF  = 4;
    localparam int IDX_W       = $clog2(NUM_IN_DEF);
    localparam int AXIS_DATA_W = 512;
    localparam int AXIS_USER_W = 128;
    localparam int BURST_W     = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_t;

endpackage

// File: rtl/depar_pkt_arbiter_if.sv
// FIFO-head inputs and registered AXI-Stream output of the arbiter.
interface depar_pkt_arbiter_if
    import depar_pkt_arbiter_pkg::*;
#(
    parameter int DW = AXIS_DATA_W,
    parameter int UW = AXIS_USER_W,
    parameter int N  = NUM_IN_DEF
) ();

    logic [N*DW-1:0]     in_tdata;
    logic [N*DW/8-1:0]   in_tkeep;
    logic [N*UW-1:0]     in_tuser;
    logic [N-1:0]        in_tlast;
    logic [N-1:0]        in_empty;
    logic [N-1:0]        in_rd_en;
    logic [DW-1:0]       arb_out_tdata;
    logic [DW/8-1:0]     arb_out_tkeep;
    logic [UW-1:0]       arb_out_tuser;
    logic                arb_out_tlast;
    logic                arb_out_tvalid;
    logic                arb_out_tready;

    modport master (
        input  in_tdata, in_tkeep, in_tuser,
        input  in_tlast, in_empty,
        input  arb_out_tready,
        output in_rd_en,
        output arb_out_tdata, arb_out_tkeep,
        output arb_out_tuser, arb_out_tlast,
        output arb_out_tvalid
    );

    modport slave (
        output in_tdata, in_tkeep, in_tuser,
        output in_tlast, in_empty,
        output arb_out_tready,
        input  in_rd_en,
        input  arb_out_tdata, arb_out_tkeep,
        input  arb_out_tuser, arb_out_tlast,
        input  arb_out_tvalid
    );

endinterface

// File: rtl/depar_pkt_arbiter_rr_pick.sv
// Circular priority encoder: first set req at or after ptr.
module depar_pkt_arbiter_rr_pick
    import depar_pkt_arbiter_pkg::*;
#(
    parameter int N = NUM_IN_DEF,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         valid
);

    logic [W:0]   sum;
    logic [W-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            // explicit wrap keeps non-power-of-2 N correct
            sum = {1'b0, ptr} + (W+1)'(k);
            if (sum >= (W+1)'(N))
                sum = sum - (W+1)'(N);
            idx = sum[W-1:0];
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/depar_pkt_arbiter.sv
// Packet-granular weighted round-robin merge of NUM_IN fallthrough
// FIFOs onto one registered AXI-Stream output.
module depar_pkt_arbiter
    import depar_pkt_arbiter_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = AXIS_DATA_W,
    parameter int C_AXIS_TUSER_WIDTH = AXIS_USER_W,
    parameter int NUM_IN             = NUM_IN_DEF,
    parameter int WEIGHT             = 2,
    localparam int GW = $clog2(NUM_IN),
    localparam int KW = C_AXIS_DATA_WIDTH / 8
) (
    input  logic                 axis_clk,
    input  logic                 reset,
    depar_pkt_arbiter_if.master  bus,
    output logic [GW-1:0]        grant_idx,
    output logic [32*NUM_IN-1:0] pkt_cnt
);

    localparam int DW = C_AXIS_DATA_WIDTH;
    localparam int UW = C_AXIS_TUSER_WIDTH;

    arb_state_t              state;
    logic [GW-1:0]           rr_ptr;
    logic [BURST_W-1:0]      burst_cnt;
    logic [NUM_IN-1:0][31:0] cnt;
    logic [GW-1:0]           winner;
    logic                    win_vld;
    logic                    slot_free;
    logic                    load;
    logic                    head_last;
    logic [GW-1:0]           next_ptr;

    assign slot_free = !bus.arb_out_tvalid
                     || bus.arb_out_tready;
    // gated by reset so an abandoned packet stays queued
    assign load = !reset && (state == SEND)
                && !bus.in_empty[grant_idx]
                && slot_free;
    assign head_last = bus.in_tlast[grant_idx];
    assign next_ptr  = (grant_idx == GW'(NUM_IN-1))
                     ? '0 : grant_idx + GW'(1);
    assign pkt_cnt   = cnt;

    always_comb begin
        bus.in_rd_en = '0;
        bus.in_rd_en[grant_idx] = load;
    end

    depar_pkt_arbiter_rr_pick #(.N(NUM_IN)) u_pick (
        .req    (~bus.in_empty),
        .ptr    (rr_ptr),
        .winner (winner),
        .valid  (win_vld)
    );

    always_ff @(posedge axis_clk) begin
        if (reset) begin
            state              <= IDLE;
            rr_ptr             <= '0;
            burst_cnt          <= '0;
            grant_idx          <= '0;
            cnt                <= '0;
            bus.arb_out_tdata  <= '0;
            bus.arb_out_tkeep  <= '0;
            bus.arb_out_tuser  <= '0;
            bus.arb_out_tlast  <= 1'b0;
            bus.arb_out_tvalid <= 1'b0;
        end else begin
            if (load) begin
                bus.arb_out_tdata <= bus.in_tdata[
                    int'(grant_idx)*DW +: DW];
                bus.arb_out_tkeep <= bus.in_tkeep[
                    int'(grant_idx)*KW +: KW];
                bus.arb_out_tuser <= bus.in_tuser[
                    int'(grant_idx)*UW +: UW];
                bus.arb_out_tlast  <= head_last;
                bus.arb_out_tvalid <= 1'b1;
            end else if (bus.arb_out_tready) begin
                bus.arb_out_tvalid <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant_idx <= winner;
                        state     <= SEND;
                        if (winner != grant_idx)
                            burst_cnt <= '0;
                    end
                end
                SEND: begin
                    if (load && head_last) begin
                        cnt[grant_idx] <= cnt[grant_idx] + 32'd1;
                        state <= IDLE;
                        if (burst_cnt == BURST_W'(WEIGHT-1)) begin
                            rr_ptr    <= next_ptr;
                            burst_cnt <= '0;
                        end else begin
                            rr_ptr    <= grant_idx;
                            burst_cnt <= burst_cnt + BURST_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_depar_pkt_arbiter.sv
// Directed bench for depar_pkt_arbiter with FIFO and sink models.
module tb_depar_pkt_arbiter;
    import depar_pkt_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int DW = 512;
    localparam int UW = 128;
    localparam int KW = DW / 8;
    localparam int GW = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    typedef struct {
        beat_t b;
        int    stamp;
    } obs_t;

    logic              axis_clk = 1'b0;
    logic              reset    = 1'b1;
    logic [GW-1:0]     grant_idx;
    logic [32*N-1:0]   pkt_cnt;

    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;
    int    rd_cnt [N];
    beat_t fq [N][$];
    obs_t  out_q [$];

    depar_pkt_arbiter_if #(.DW(DW), .UW(UW), .N(N)) bus ();

    depar_pkt_arbiter #(
        .C_AXIS_DATA_WIDTH  (DW),
        .C_AXIS_TUSER_WIDTH (UW),
        .NUM_IN             (N),
        .WEIGHT             (2)
    ) dut (
        .axis_clk  (axis_clk),
        .reset     (reset),
        .bus       (bus),
        .grant_idx (grant_idx),
        .pkt_cnt   (pkt_cnt)
    );

    always #5 axis_clk = ~axis_clk;

    function automatic beat_t mk(int src, int pkt, int beat, logic last);
        beat_t b;
        b.data = (DW'(src) << 16) | (DW'(pkt) << 8) | DW'(beat);
        b.keep = last ? KW'(16'h0FFF) : '1;
        b.user = UW'(32'hC0DE_0000) | UW'(src*256 + beat);
        b.last = last;
        return b;
    endfunction

    function automatic void push_beat(int src, int pkt, int beat, logic last);
        fq[src].push_back(mk(src, pkt, beat, last));
    endfunction

    task automatic drive_heads();
        for (int i = 0; i < N; i++) begin
            if (fq[i].size() > 0) begin
                bus.in_tdata[i*DW +: DW] = fq[i][0].data;
                bus.in_tkeep[i*KW +: KW] = fq[i][0].keep;
                bus.in_tuser[i*UW +: UW] = fq[i][0].user;
                bus.in_tlast[i]          = fq[i][0].last;
                bus.in_empty[i]          = 1'b0;
            end else begin
                bus.in_tdata[i*DW +: DW] = '0;
                bus.in_tkeep[i*KW +: KW] = '0;
                bus.in_tuser[i*UW +: UW] = '0;
                bus.in_tlast[i]          = 1'b0;
                bus.in_empty[i]          = 1'b1;
            end
        end
    endtask

    // FIFO pop model plus output sink monitor
    initial begin
        logic [N-1:0] rd;
        obs_t o;
        for (int i = 0; i < N; i++) rd_cnt[i] = 0;
        drive_heads();
        forever begin
            @(posedge axis_clk);
            cyc++;
            rd = bus.in_rd_en;
            if (!reset && bus.arb_out_tvalid && bus.arb_out_tready) begin
                o.b.data = bus.arb_out_tdata;
                o.b.keep = bus.arb_out_tkeep;
                o.b.user = bus.arb_out_tuser;
                o.b.last = bus.arb_out_tlast;
                o.stamp  = cyc;
                out_q.push_back(o);
            end
            if (rd != '0) begin
                tests++;
                if ($countones(rd) != 1) begin
                    fails++;
                    $display("FAIL rd_en_onehot: got %b want one bit", rd);
                end
            end
            #1;
            for (int i = 0; i < N; i++) begin
                if (rd[i]) begin
                    rd_cnt[i]++;
                    if (fq[i].size() > 0) void'(fq[i].pop_front());
                    else begin
                        fails++;
                        $display("FAIL rd_en_underflow: input %0d popped while empty", i);
                    end
                end
            end
            drive_heads();
            @(negedge axis_clk);
            #1 drive_heads();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    task automatic wait_until(int n, int budget, output bit ok);
        int c = 0;
        while (out_q.size() < n && c < budget) begin
            @(negedge axis_clk);
            c++;
        end
        ok = (out_q.size() >= n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge axis_clk);
        @(negedge axis_clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.arb_out_tready = 1'b1;
        repeat (3) @(negedge axis_clk);
        tests++;
        if (bus.arb_out_tvalid !== 1'b0 || bus.arb_out_tlast !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid: got v=%b l=%b want 0 0",
                     bus.arb_out_tvalid, bus.arb_out_tlast);
        end
        tests++;
        if (bus.arb_out_tdata !== '0 || bus.in_rd_en !== '0) begin
            fails++;
            $display("FAIL reset_data: got d=%h rd=%b want 0 0",
                     bus.arb_out_tdata[31:0], bus.in_rd_en);
        end
        tests++;
        if (grant_idx !== '0 || pkt_cnt !== '0) begin
            fails++;
            $display("FAIL reset_cnt: got g=%0d c=%h want 0 0", grant_idx, pkt_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        int b, r0; bit ok; beat_t e;
        b  = out_q.size();
        r0 = rd_cnt[0];
        for (int k = 0; k < 3; k++) push_beat(0, 1, k, k == 2);
        wait_until(b + 3, 30, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL single_timeout: got %0d beats want 3", out_q.size() - b);
        end
        repeat (3) @(negedge axis_clk);
        tests++;
        if (out_q.size() !== b + 3) begin
            fails++;
            $display("FAIL single_count: got %0d want 3", out_q.size() - b);
        end
        for (int k = 0; k < 3 && b + k < out_q.size(); k++) begin
            e = mk(0, 1, k, k == 2);
            tests++;
            if ({out_q[b+k].b.data, out_q[b+k].b.keep, out_q[b+k].b.user,
                 out_q[b+k].b.last} !== {e.data, e.keep, e.user, e.last}) begin
                fails++;
                $display("FAIL single_beat%0d: got d=%h l=%b want d=%h l=%b", k,
                         out_q[b+k].b.data[31:0], out_q[b+k].b.last,
                         e.data[31:0], e.last);
            end
        end
        tests++;
        if (pkt_cnt[31:0] !== 32'd1) begin
            fails++;
            $display("FAIL single_pkt_cnt: got %0d want 1", pkt_cnt[31:0]);
        end
        tests++;
        if (rd_cnt[0] - r0 != 3) begin
            fails++;
            $display("FAIL single_rd_en: got %0d cycles want 3", rd_cnt[0] - r0);
        end
        tests++;
        if (bus.arb_out_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL single_drain: got tvalid=%b want 0", bus.arb_out_tvalid);
        end
    endtask

    task automatic test_wrr();
        int b, s; bit ok;
        int exp_src [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 1, 2, 3};
        do_reset();
        b = out_q.size();
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < N; i++) push_beat(i, p, 0, 1'b1);
        wait_until(b + 12, 100, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL wrr_timeout: got %0d beats want 12", out_q.size() - b);
        end
        for (int k = 0; k < 12 && b + k < out_q.size(); k++) begin
            s = int'(out_q[b+k].b.data[23:16]);
            tests++;
            if (s != exp_src[k]) begin
                fails++;
                $display("FAIL wrr_order%0d: got src %0d want %0d", k, s, exp_src[k]);
            end
        end
        if (ok) begin
            tests++;
            if (out_q[b+11].stamp - out_q[b].stamp != 22) begin
                fails++;
                $display("FAIL wrr_bubble: got span %0d want 22",
                         out_q[b+11].stamp - out_q[b].stamp);
            end
        end
        for (int i = 0; i < N; i++) begin
            tests++;
            if (pkt_cnt[i*32 +: 32] !== 32'd3) begin
                fails++;
                $display("FAIL wrr_pkt_cnt%0d: got %0d want 3", i, pkt_cnt[i*32 +: 32]);
            end
        end
    endtask

    task automatic test_stall();
        int b, s, bt; bit ok;
        int exp_src [5] = '{1, 1, 1, 1, 2};
        int exp_bt  [5] = '{0, 1, 2, 3, 0};
        do_reset();
        b = out_q.size();
        push_beat(1, 0, 0, 1'b0);
        push_beat(1, 0, 1, 1'b0);
        push_beat(2, 0, 0, 1'b1);
        repeat (12) @(negedge axis_clk);
        tests++;
        if (out_q.size() !== b + 2) begin
            fails++;
            $display("FAIL stall_count: got %0d want 2", out_q.size() - b);
        end
        tests++;
        if (grant_idx !== 2'd1 || bus.arb_out_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL stall_hold: got g=%0d v=%b want 1 0",
                     grant_idx, bus.arb_out_tvalid);
        end
        push_beat(1, 0, 2, 1'b0);
        push_beat(1, 0, 3, 1'b1);
        wait_until(b + 5, 40, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL stall_timeout: got %0d beats want 5", out_q.size() - b);
        end
        for (int k = 0; k < 5 && b + k < out_q.size(); k++) begin
            s  = int'(out_q[b+k].b.data[23:16]);
            bt = int'(out_q[b+k].b.data[7:0]);
            tests++;
            if (s != exp_src[k] || bt != exp_bt[k]) begin
                fails++;
                $display("FAIL stall_order%0d: got %0d.%0d want %0d.%0d",
                         k, s, bt, exp_src[k], exp_bt[k]);
            end
        end
        tests++;
        if (pkt_cnt[63:32] !== 32'd1 || pkt_cnt[95:64] !== 32'd1) begin
            fails++;
            $display("FAIL stall_pkt_cnt: got %0d %0d want 1 1",
                     pkt_cnt[63:32], pkt_cnt[95:64]);
        end
    endtask

    task automatic test_backpressure();
        int b, sz; bit ok; beat_t e;
        logic [DW-1:0] hd; logic hl;
        b = out_q.size();
        for (int k = 0; k < 64; k++) push_beat(2, 5, k, k == 63);
        wait_until(b + 10, 100, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL bp_start: got %0d beats want 10", out_q.size() - b);
        end
        hd = bus.arb_out_tdata;
        hl = bus.arb_out_tlast;
        sz = out_q.size();
        bus.arb_out_tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge axis_clk);
            tests++;
            if (bus.arb_out_tvalid !== 1'b1 || bus.arb_out_tdata !== hd
                || bus.arb_out_tlast !== hl || bus.in_rd_en !== '0) begin
                fails++;
                $display("FAIL bp_hold%0d: got v=%b d=%h rd=%b want 1 %h 0", c,
                         bus.arb_out_tvalid, bus.arb_out_tdata[31:0],
                         bus.in_rd_en, hd[31:0]);
            end
        end
        tests++;
        if (out_q.size() !== sz) begin
            fails++;
            $display("FAIL bp_accept: got %0d want %0d", out_q.size(), sz);
        end
        bus.arb_out_tready = 1'b1;
        wait_until(b + 64, 200, ok);
        repeat (4) @(negedge axis_clk);
        tests++;
        if (out_q.size() !== b + 64 || fq[2].size() != 0) begin
            fails++;
            $display("FAIL bp_total: got %0d beats left %0d want 64 0",
                     out_q.size() - b, fq[2].size());
        end
        for (int k = 0; k < 64 && b + k < out_q.size(); k++) begin
            e = mk(2, 5, k, k == 63);
            tests++;
            if ({out_q[b+k].b.data, out_q[b+k].b.keep, out_q[b+k].b.user,
                 out_q[b+k].b.last} !== {e.data, e.keep, e.user, e.last}) begin
                fails++;
                $display("FAIL bp_beat%0d: got d=%h l=%b want d=%h l=%b", k,
                         out_q[b+k].b.data[31:0], out_q[b+k].b.last,
                         e.data[31:0], e.last);
            end
        end
    endtask

    task automatic test_mid_reset();
        int b; bit ok;
        push_beat(2, 6, 0, 1'b1);
        b = out_q.size();
        wait_until(b + 1, 20, ok);
        b = out_q.size();
        for (int k = 0; k < 4; k++) push_beat(2, 7, k, k == 3);
        wait_until(b + 1, 30, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL mreset_start: got %0d beats want 1", out_q.size() - b);
        end
        reset = 1'b1;
        @(negedge axis_clk);
        reset = 1'b0;
        tests++;
        if (bus.arb_out_tvalid !== 1'b0 || pkt_cnt !== '0 || grant_idx !== '0) begin
            fails++;
            $display("FAIL mreset_state: got v=%b c=%h g=%0d want 0 0 0",
                     bus.arb_out_tvalid, pkt_cnt, grant_idx);
        end
        tests++;
        if (fq[2].size() != 2 || out_q.size() !== b + 1) begin
            fails++;
            $display("FAIL mreset_drain: got left=%0d out=%0d want 2 1",
                     fq[2].size(), out_q.size() - b);
        end
        push_beat(1, 8, 0, 1'b1);
        wait_until(b + 4, 40, ok);
        tests++;
        if (!ok || out_q[b+1].b.data[23:0] !== 24'h010800) begin
            fails++;
            $display("FAIL mreset_rr: got %h want 010800",
                     out_q[out_q.size()-1].b.data[23:0]);
        end
        tests++;
        if (!ok || out_q[b+2].b.data[23:0] !== 24'h020702
            || out_q[b+3].b.data[23:0] !== 24'h020703) begin
            fails++;
            $display("FAIL mreset_orphan: got %0d beats want 020702 020703",
                     out_q.size() - b);
        end
        repeat (2) @(negedge axis_clk);
        tests++;
        if (pkt_cnt !== {32'd0, 32'd1, 32'd1, 32'd0}) begin
            fails++;
            $display("FAIL mreset_pkt_cnt: got %h want 0 1 1 0", pkt_cnt);
        end
    endtask

    task automatic test_idle_latency();
        bit bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge axis_clk);
            if (bus.arb_out_tvalid !== 1'b0 || bus.in_rd_en !== '0) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL idle_quiet: got activity want none");
        end
        push_beat(3, 9, 0, 1'b1);
        @(negedge axis_clk);
        tests++;
        if (grant_idx !== 2'd3 || bus.arb_out_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL idle_grant: got g=%0d v=%b want 3 0",
                     grant_idx, bus.arb_out_tvalid);
        end
        @(negedge axis_clk);
        tests++;
        if (bus.arb_out_tvalid !== 1'b1 || bus.arb_out_tlast !== 1'b1
            || bus.arb_out_tdata[23:0] !== 24'h030900) begin
            fails++;
            $display("FAIL idle_first_beat: got v=%b d=%h want 1 030900",
                     bus.arb_out_tvalid, bus.arb_out_tdata[23:0]);
        end
        repeat (3) @(negedge axis_clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrr();
        test_stall();
        test_backpressure();
        test_mid_reset();
        test_idle_latency();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
